// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and types for the clocked 8-to-3 priority encoder.
package enc_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);
    typedef logic [N-1:0] req_t;
    typedef logic [W-1:0] code_t;
endpackage

// File: rtl/prio_encoder_8to3_if.sv
// prio_encoder_8to3_if: valid/ready grant channel carrying the encoded index.
interface prio_encoder_8to3_if;
    enc_pkg::code_t y;
    logic valid;
    logic ready;
    modport master(output y, valid, input ready);
    modport slave(input y, valid, output ready);
endinterface

// File: rtl/prio_encoder_8to3_prio_pick.sv
// prio_pick: first set bit of mask searching downward from start, wrapping 0 -> N-1.
module prio_pick
    import enc_pkg::*;
(
    input  req_t  i_mask,
    input  code_t i_start,
    output code_t o_idx,
    output logic  o_any
);
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_mask[i_start - code_t'(k)]) o_idx = i_start - code_t'(k);
        end
    end
    assign o_any = |i_mask;
endmodule

// File: rtl/prio_encoder_8to3.sv
// prio_encoder_8to3: event-capturing 8-to-3 priority encoder with valid/ready grant and 74x148-style cascade.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 7 highest).
module prio_encoder_8to3
    import enc_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  req_t                       i_req_l,
    input  logic                       i_ei_l,
    prio_encoder_8to3_if.master        bus,
    output logic                       o_gs_l,
    output logic                       o_eo_l,
    output logic                       o_ovf
);
    req_t  r_in, r_samp, r_pend;
    code_t r_y;
    logic  r_valid, r_ovf;
    req_t  w_set, w_clr, w_next;
    code_t w_idx, w_start;
    logic  w_any, w_load, w_launch;
    // r_in registers the raw lines; an event is a 1 -> 0 step between r_samp and r_in
    assign w_set    = i_ei_l ? '0 : (r_samp & ~r_in);
    assign w_clr    = (r_valid & bus.ready) ? (req_t'(1) << r_y) : '0;
    assign w_next   = (r_pend & ~w_clr) | w_set;
    assign w_load   = ~r_valid | bus.ready;
    assign w_launch = w_load & w_any & ~i_ei_l;
`ifdef ROUND_ROBIN_EN
    code_t r_rr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rr <= code_t'(N - 1);
        else if (w_launch) r_rr <= w_idx - code_t'(1);
    end
    assign w_start = r_rr;
`else
    assign w_start = code_t'(N - 1);
`endif
    prio_pick u_pick (
        .i_mask  (w_next),
        .i_start (w_start),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in    <= '1;
            r_samp  <= '1;
            r_pend  <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_in   <= i_req_l;
            r_samp <= r_in;
            r_pend <= w_next;
            r_ovf  <= r_ovf | (|(w_set & r_pend & ~w_clr));
            if (w_load) r_valid <= w_launch;
            if (w_launch) r_y <= w_idx;
        end
    end
    assign bus.y   = r_y;
    assign bus.valid = r_valid;
    assign o_gs_l  = ~(|r_pend | r_valid);
    assign o_eo_l  = i_ei_l | ~o_gs_l;
    assign o_ovf   = r_ovf;
endmodule

// File: tb/tb_prio_encoder_8to3.sv
// tb_prio_encoder_8to3: directed vector table, hand sequences and a randomized run against a reference model.
module tb_prio_encoder_8to3;
    import enc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    req_t req_l = '1;
    logic ei_l = 1'b0;
    logic gs_l, eo_l, ovf;
    int   n_chk = 0;
    int   n_pass = 0;

    prio_encoder_8to3_if bus();

    prio_encoder_8to3 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req_l (req_l),
        .i_ei_l  (ei_l),
        .bus     (bus.master),
        .o_gs_l  (gs_l),
        .o_eo_l  (eo_l),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: a set of pending requests plus a single grant slot.
    typedef struct {
        req_t  cur, prev, pend;
        code_t y, rr;
        logic  v, ov;
    } model_t;
    model_t m;

    function automatic int pick(input req_t p, input int start);
        int idx = 0;
`ifdef ROUND_ROBIN_EN
        for (int s = 7; s >= 0; s--) if (p[(start - s + 8) % 8]) idx = (start - s + 8) % 8;
`else
        for (int i = 0; i < 8; i++) if (p[i]) idx = i;
`endif
        return idx;
    endfunction

    function automatic model_t step(input model_t s, input req_t req, input logic ei, input logic rdy);
        model_t n = s;
        req_t ev = '0, gone = '0, nxt;
        for (int i = 0; i < 8; i++) if (!ei && s.prev[i] && !s.cur[i]) ev[i] = 1'b1;
        if (s.v && rdy) gone[s.y] = 1'b1;
        nxt = (s.pend & ~gone) | ev;
        if ((ev & s.pend & ~gone) != 0) n.ov = 1'b1;
        if (!s.v || rdy) begin
            n.v = !ei && nxt != 0;
            if (n.v) begin
                n.y = code_t'(pick(nxt, int'(s.rr)));
                n.rr = code_t'((int'(n.y) + 7) % 8);
            end
        end
        n.pend = nxt;
        n.prev = s.cur;
        n.cur = req;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{cur: '1, prev: '1, pend: '0, y: '0, rr: 3'd7, v: 1'b0, ov: 1'b0};
        else m <= step(m, req_l, ei_l, bus.ready);
    end

    typedef struct {
        req_t  req;
        logic  ei, rdy, v;
        code_t y;
        logic  gs, eo, ov;
    } vec_t;
    vec_t tbl[24];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // req ei rdy | valid y gs eo ovf  (state after the edge)
        tbl[0]  = '{8'hFB, 0, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{8'hFB, 0, 1, 1, 2, 0, 1, 0};
        tbl[2]  = '{8'hFB, 0, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{8'hFF, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{8'h5E, 0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{8'h5E, 0, 0, 1, 7, 0, 1, 0};
        tbl[6]  = '{8'h5E, 0, 0, 1, 7, 0, 1, 0};
        tbl[7]  = '{8'h5E, 0, 1, 1, 5, 0, 1, 0};
        tbl[8]  = '{8'h5E, 0, 1, 1, 0, 0, 1, 0};
        tbl[9]  = '{8'h5E, 0, 1, 0, 0, 1, 0, 0};
        tbl[10] = '{8'hFF, 0, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{8'hF7, 0, 0, 0, 0, 1, 0, 0};
        tbl[12] = '{8'hF7, 0, 0, 1, 3, 0, 1, 0};
        tbl[13] = '{8'hFF, 0, 0, 1, 3, 0, 1, 0};
        tbl[14] = '{8'hF7, 0, 0, 1, 3, 0, 1, 0};
        tbl[15] = '{8'hF7, 0, 0, 1, 3, 0, 1, 1};
        tbl[16] = '{8'hF7, 0, 1, 0, 0, 1, 0, 1};
        tbl[17] = '{8'hF7, 0, 1, 0, 0, 1, 0, 1};
        tbl[18] = '{8'hFF, 1, 1, 0, 0, 1, 1, 1};
        tbl[19] = '{8'hEF, 1, 1, 0, 0, 1, 1, 1};
        tbl[20] = '{8'hEF, 1, 1, 0, 0, 1, 1, 1};
        tbl[21] = '{8'hFF, 1, 1, 0, 0, 1, 1, 1};
        tbl[22] = '{8'hFF, 1, 1, 0, 0, 1, 1, 1};
        tbl[23] = '{8'hFF, 0, 1, 0, 0, 1, 0, 1};

        bus.ready = 1'b1;
        #1;
        chk("reset valid", bus.valid, 0);
        chk("reset y", bus.y, 0);
        chk("reset gs_l", gs_l, 1);
        chk("reset eo_l", eo_l, 0);
        chk("reset ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req_l = tbl[i].req;
            ei_l = tbl[i].ei;
            bus.ready = tbl[i].rdy;
            cyc();
            chk($sformatf("vec%0d valid", i), bus.valid, tbl[i].v);
            if (tbl[i].v) chk($sformatf("vec%0d y", i), bus.y, tbl[i].y);
            chk($sformatf("vec%0d gs_l", i), gs_l, tbl[i].gs);
            chk($sformatf("vec%0d eo_l", i), eo_l, tbl[i].eo);
            chk($sformatf("vec%0d ovf", i), ovf, tbl[i].ov);
        end

        // Async reset while a grant is waiting for READY
        req_l = 8'hFD;
        bus.ready = 1'b0;
        cyc();
        cyc();
        chk("pre-reset valid", bus.valid, 1);
        chk("pre-reset y", bus.y, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", bus.valid, 0);
        chk("async reset y", bus.y, 0);
        chk("async reset ovf", ovf, 0);
        chk("async reset gs_l", gs_l, 1);
        req_l = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("post-reset idle%0d valid", i), bus.valid, 0);
        end

        // Accept of 7 on the same edge as a fresh event on 7, with 6 also pending
        req_l = 8'h3F;
        cyc();
        cyc();
        chk("pair first y", bus.y, 7);
        req_l = 8'hBF;
        cyc();
        req_l = 8'h3F;
        cyc();
        bus.ready = 1'b1;
        cyc();
        chk("pair accept valid", bus.valid, 1);
`ifdef ROUND_ROBIN_EN
        chk("pair second y", bus.y, 6);
        cyc();
        chk("pair third y", bus.y, 7);
`else
        chk("pair second y", bus.y, 7);
        cyc();
        chk("pair third y", bus.y, 6);
`endif
        chk("pair set-wins ovf", ovf, 0);
        cyc();
        chk("pair drained valid", bus.valid, 0);

        // Randomized run against the model
        rst_n = 1'b0;
        req_l = '1;
        ei_l = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd valid", bus.valid, m.v);
            if (m.v) chk("rnd y", bus.y, m.y);
            chk("rnd gs_l", gs_l, !(m.pend != 0 || m.v));
            chk("rnd eo_l", eo_l, ei_l || (m.pend != 0 || m.v));
            chk("rnd ovf", ovf, m.ov);
            req_l = req_l ^ req_t'($urandom & $urandom & $urandom);
            ei_l = ($urandom_range(0, 11) == 0);
            bus.ready = ($urandom_range(0, 2) != 0);
            if (c == 700) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
